userio_event_sched: RTL and testbench

- System-clock scheduler for the keyboard/mouse byte stream produced by the SPI user I/O receiver.
- Detects the receiver's toggle-level event flag across the clock boundary and captures the accompanying type/data byte into a small FIFO.
- Dispatches each FIFO entry to one of three consumers:
  - Amiga mouse X/Y position counters, applied immediately.
  - Keyboard path, valid/ready handshake.
  - OSD keyboard path, valid/ready handshake.

---
 rtl/userio_pkg.sv | 20 ++
 rtl/userio_fifo.sv | 51 +++++
 rtl/userio_event_sched.sv | 109 ++++++++++
 tb/tb_userio_event_sched.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/userio_pkg.sv
// rtl/userio_pkg.sv - shared event codes, dispatch states and FIFO entry layout
package userio_pkg;

  localparam logic [1:0] EV_MOUSE_X = 2'd0;
  localparam logic [1:0] EV_MOUSE_Y = 2'd1;
  localparam logic [1:0] EV_KEY     = 2'd2;
  localparam logic [1:0] EV_OSD     = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KEY  = 2'd1,
    OSD  = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [1:0] ev_type;
    logic [7:0] data;
  } ev_entry_t;

endpackage

// File: rtl/userio_fifo.sv
// rtl/userio_fifo.sv - synchronous FIFO; a push while full is accepted when a pop frees a slot
module userio_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/userio_event_sched.sv
// rtl/userio_event_sched.sv - captures SPI-side keyboard/mouse events and dispatches them in order
module userio_event_sched
  import userio_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kms_level,
  input  logic [1:0] kms_type,
  input  logic [7:0] kms_data,
  output logic [7:0] mouse_x,
  output logic [7:0] mouse_y,
  output logic [7:0] key_data,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] osd_data,
  output logic       osd_valid,
  input  logic       osd_ready,
  output logic       ovf,
  output logic [7:0] drop_cnt
);

  logic         sync1, sync2, sync3;
  logic         event_hit;
  logic         fifo_full, fifo_empty, fifo_pop, drop;
  ev_entry_t    head;
  sched_state_t state;

  // Type/data are stable by the time the toggle has crossed, so they are sampled raw.
  assign event_hit = sync2 ^ sync3;
  assign fifo_pop  = (state == IDLE) && !fifo_empty;
  assign drop      = event_hit && fifo_full && !fifo_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= kms_level;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  userio_fifo #(.WIDTH(10), .DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (event_hit),
    .wdata ({kms_type, kms_data}),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf      <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mouse_x   <= 8'd0;
      mouse_y   <= 8'd0;
      key_data  <= 8'd0;
      key_valid <= 1'b0;
      osd_data  <= 8'd0;
      osd_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!fifo_empty) begin
          case (head.ev_type)
            EV_MOUSE_X: mouse_x <= mouse_x + head.data;
            EV_MOUSE_Y: mouse_y <= mouse_y + head.data;
            EV_KEY: begin
              key_data  <= head.data;
              key_valid <= 1'b1;
              state     <= KEY;
            end
            default: begin
              osd_data  <= head.data;
              osd_valid <= 1'b1;
              state     <= OSD;
            end
          endcase
        end
        KEY: if (key_ready) begin
          key_valid <= 1'b0;
          state     <= IDLE;
        end
        OSD: if (osd_ready) begin
          osd_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_userio_event_sched.sv
// tb/tb_userio_event_sched.sv - directed and randomized checks of userio_event_sched
module tb_userio_event_sched;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       kms_level = 1'b0;
  logic [1:0] kms_type = 2'd0;
  logic [7:0] kms_data = 8'd0;
  logic       key_ready = 1'b0;
  logic       osd_ready = 1'b0;
  logic [7:0] mouse_x, mouse_y, key_data, osd_data, drop_cnt;
  logic       key_valid, osd_valid, ovf;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] got_key[$];
  logic [7:0] got_osd[$];
  logic [7:0] exp_key[$];
  logic [7:0] exp_osd[$];

  logic       pk_v = 1'b0, pk_r = 1'b0, po_v = 1'b0, po_r = 1'b0;
  logic [7:0] pk_d = 8'd0, po_d = 8'd0;

  userio_event_sched #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .kms_level (kms_level),
    .kms_type  (kms_type),
    .kms_data  (kms_data),
    .mouse_x   (mouse_x),
    .mouse_y   (mouse_y),
    .key_data  (key_data),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .osd_data  (osd_data),
    .osd_valid (osd_valid),
    .osd_ready (osd_ready),
    .ovf       (ovf),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [1:0] t, input logic [7:0] d);
    kms_type  = t;
    kms_data  = d;
    kms_level = ~kms_level;
    ticks(4);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    kms_level = 1'b0;
    key_ready = 1'b0;
    osd_ready = 1'b0;
    ticks(2);
    reset = 1'b0;
    got_key.delete();
    got_osd.delete();
  endtask

  // Handshake monitor: records accepted bytes and checks valid/data hold under back-pressure.
  always @(negedge clk) begin
    if (reset) begin
      pk_v <= 1'b0;
      po_v <= 1'b0;
    end else begin
      if (pk_v && !pk_r) begin
        chk("key_hold_valid", key_valid, 1);
        chk("key_hold_data", key_data, pk_d);
      end
      if (po_v && !po_r) begin
        chk("osd_hold_valid", osd_valid, 1);
        chk("osd_hold_data", osd_data, po_d);
      end
      if (key_valid && key_ready) got_key.push_back(key_data);
      if (osd_valid && osd_ready) got_osd.push_back(osd_data);
      pk_v <= key_valid; pk_r <= key_ready; pk_d <= key_data;
      po_v <= osd_valid; po_r <= osd_ready; po_d <= osd_data;
    end
  end

  initial begin
    int         lat;
    int         ks, os;
    logic [1:0] t;
    logic [7:0] d;
    logic [7:0] mx, my;
    logic [7:0] g;

    do_reset();
    chk("rst_mouse_x", mouse_x, 0);
    chk("rst_mouse_y", mouse_y, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_osd_valid", osd_valid, 0);
    chk("rst_key_data", key_data, 0);
    chk("rst_osd_data", osd_data, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_drop_cnt", drop_cnt, 0);

    // Single keycode: sync (2) + FIFO write (1) + FSM load (1) edges after the toggle.
    key_ready = 1'b1;
    kms_type  = 2'd2;
    kms_data  = 8'h45;
    kms_level = ~kms_level;
    lat = 0;
    while (!key_valid && lat < 12) begin
      tick();
      lat++;
    end
    chk("t1_latency", lat, 4);
    chk("t1_key_data", key_data, 8'h45);
    chk("t1_mouse_x", mouse_x, 0);
    chk("t1_mouse_y", mouse_y, 0);
    tick();
    chk("t1_one_cycle", key_valid, 0);
    ticks(2);
    chk("t1_accepted", got_key.size(), 1);

    // Mouse counters wrap modulo 256.
    do_reset();
    send(2'd0, 8'h7F);
    send(2'd0, 8'h02);
    send(2'd1, 8'hFF);
    ticks(2);
    chk("t2_mouse_x", mouse_x, 8'h81);
    chk("t2_mouse_y", mouse_y, 8'hFF);

    // A stalled key blocks the mouse moves queued behind it.
    do_reset();
    send(2'd2, 8'h10);
    send(2'd0, 8'h05);
    send(2'd0, 8'h03);
    chk("t3_key_valid", key_valid, 1);
    chk("t3_key_data", key_data, 8'h10);
    chk("t3_mouse_blocked", mouse_x, 0);
    key_ready = 1'b1;
    tick();
    chk("t3_key_released", key_valid, 0);
    chk("t3_mouse_still", mouse_x, 0);
    tick();
    chk("t3_mouse_first", mouse_x, 8'h05);
    tick();
    chk("t3_mouse_second", mouse_x, 8'h08);

    // Overflow: OSD stalls in the FSM, DEPTH keys fill the FIFO, two are dropped.
    do_reset();
    send(2'd3, 8'hA0);
    for (int i = 0; i < DEPTH + 2; i++) send(2'd2, 8'hB0 + 8'(i));
    chk("t4_ovf", ovf, 1);
    chk("t4_drop_cnt", drop_cnt, 2);
    chk("t4_osd_valid", osd_valid, 1);
    chk("t4_osd_data", osd_data, 8'hA0);
    chk("t4_key_blocked", key_valid, 0);
    key_ready = 1'b1;
    osd_ready = 1'b1;
    ticks(14);
    chk("t4_osd_count", got_osd.size(), 1);
    g = (got_osd.size() > 0) ? got_osd[0] : 8'hxx;
    chk("t4_osd_byte", g, 8'hA0);
    chk("t4_key_count", got_key.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      g = (i < got_key.size()) ? got_key[i] : 8'hxx;
      chk($sformatf("t4_key_%0d", i), g, 8'hB0 + 8'(i));
    end

    // Drop counter saturates.
    do_reset();
    for (int i = 0; i < DEPTH + 1 + 300; i++) send(2'd2, 8'(i));
    chk("t5_drop_sat", drop_cnt, 8'hFF);
    chk("t5_ovf", ovf, 1);

    // Reset mid-handshake with a partly filled FIFO.
    do_reset();
    key_ready = 1'b1;
    send(2'd3, 8'hC0);
    for (int i = 0; i < 3; i++) send(2'd2, 8'hD0 + 8'(i));
    chk("t6_osd_pending", osd_valid, 1);
    reset     = 1'b1;
    kms_level = 1'b0;
    tick();
    chk("t6_osd_valid", osd_valid, 0);
    chk("t6_osd_data", osd_data, 0);
    chk("t6_key_valid", key_valid, 0);
    chk("t6_ovf", ovf, 0);
    reset = 1'b0;
    ticks(6);
    chk("t6_fifo_empty", got_key.size(), 0);
    chk("t6_no_osd", osd_valid, 0);
    send(2'd2, 8'h5A);
    ticks(2);
    chk("t6_new_count", got_key.size(), 1);
    g = (got_key.size() > 0) ? got_key[0] : 8'hxx;
    chk("t6_new_byte", g, 8'h5A);

    // Randomized traffic against an order-preserving queue model.
    do_reset();
    exp_key.delete();
    exp_osd.delete();
    mx = 8'd0;
    my = 8'd0;
    ks = 0;
    os = 0;
    for (int n = 0; n < 40; n++) begin
      t = 2'($urandom);
      d = 8'($urandom);
      case (t)
        2'd0:    mx = mx + d;
        2'd1:    my = my + d;
        2'd2:    exp_key.push_back(d);
        default: exp_osd.push_back(d);
      endcase
      kms_type  = t;
      kms_data  = d;
      kms_level = ~kms_level;
      for (int k = 0; k < 6; k++) begin
        key_ready = (ks >= 2) ? 1'b1 : 1'($urandom % 2);
        osd_ready = (os >= 2) ? 1'b1 : 1'($urandom % 2);
        ks = key_ready ? 0 : ks + 1;
        os = osd_ready ? 0 : os + 1;
        tick();
      end
    end
    key_ready = 1'b1;
    osd_ready = 1'b1;
    ticks(10);
    chk("rnd_mouse_x", mouse_x, mx);
    chk("rnd_mouse_y", mouse_y, my);
    chk("rnd_no_drop", drop_cnt, 0);
    chk("rnd_key_count", got_key.size(), exp_key.size());
    chk("rnd_osd_count", got_osd.size(), exp_osd.size());
    foreach (exp_key[i]) begin
      g = (i < got_key.size()) ? got_key[i] : 8'hxx;
      chk($sformatf("rnd_key_%0d", i), g, exp_key[i]);
    end
    foreach (exp_osd[i]) begin
      g = (i < got_osd.size()) ? got_osd[i] : 8'hxx;
      chk($sformatf("rnd_osd_%0d", i), g, exp_osd[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
